// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral
//
// SPI mode-0 peripheral that gives an external controller read and write
// access to a bank of NUM_REGS control registers of DATA_W bits each.
// A frame is one nCS low period, MSB first:
//   R/W bit (1 = write) | ADDR_W address bits | DATA_W data bits
//
// Optional feature macro: SPI_READBACK_EN
//   defined   - read frames shift register contents out on CIPO
//   undefined - no transmit path, CIPO and cipo_oe held at 0, reads discarded
//
// Ports:
//   clk        in   system clock, all logic on rising edge
//   rst_n      in   synchronous active-low reset
//   nCS        in   SPI chip select, active-low (asynchronous to clk)
//   SCLK       in   SPI clock (asynchronous to clk)
//   COPI       in   controller-out data (asynchronous to clk)
//   CIPO       out  peripheral-out data
//   cipo_oe    out  output enable for the CIPO pad
//   regs_flat  out  register i at bits [i*DATA_W +: DATA_W]
//   wr_strobe  out  one-cycle pulse on bit i when register i is written

module spi_regfile_peripheral #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         nCS,
  input  logic                         SCLK,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  // Bit-counter values: count before the last address bit, after the
  // command field, before the last data bit, and the saturation value.
  localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_CMD_DONE  = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t state, state_next;

  logic [1:0] ncs_sync, sclk_sync, copi_sync;
  logic       ncs_hist, sclk_hist, copi_hist;
  logic       ncs_fall, ncs_rise, sclk_rise, sclk_fall;

  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_LEN-2:0] rx_shift;
  logic [FRAME_LEN-1:0] rx_next;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_W-1:0]    wr_data;

  logic take_bit, commit_wr, clear_frame;

  // Two-flop synchronisers plus a history flop per pin. The edge flags are
  // registered, so an edge is acted on by the FSM on the 4th clk rising
  // edge after the pin transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ncs_sync  <= 2'b11;
      sclk_sync <= 2'b00;
      copi_sync <= 2'b00;
      ncs_hist  <= 1'b1;
      sclk_hist <= 1'b0;
      copi_hist <= 1'b0;
      ncs_fall  <= 1'b0;
      ncs_rise  <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      ncs_sync  <= {ncs_sync[0], nCS};
      sclk_sync <= {sclk_sync[0], SCLK};
      copi_sync <= {copi_sync[0], COPI};
      ncs_hist  <= ncs_sync[1];
      sclk_hist <= sclk_sync[1];
      copi_hist <= copi_sync[1];
      ncs_fall  <= ~ncs_sync[1] &  ncs_hist;
      ncs_rise  <=  ncs_sync[1] & ~ncs_hist;
      sclk_rise <=  sclk_sync[1] & ~sclk_hist;
      sclk_fall <= ~sclk_sync[1] &  sclk_hist;
    end
  end

  // Frame contents including the bit being sampled this cycle.
  assign rx_next = {rx_shift, copi_hist};
  assign wr_addr = rx_next[DATA_W +: ADDR_W];
  assign wr_data = rx_next[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A commit raised together with an nCS rising edge still happens; only
  // the state is forced back to IDLE.
  always_comb begin
    state_next  = state;
    take_bit    = 1'b0;
    commit_wr   = 1'b0;
    clear_frame = 1'b0;
    unique case (state)
      IDLE: begin
        if (ncs_fall) begin
          state_next  = CMD;
          clear_frame = 1'b1;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          take_bit = 1'b1;
          if (bit_cnt == CNT_CMD_LAST) state_next = DATA;
        end
      end
      DATA: begin
        if (sclk_rise) begin
          take_bit = 1'b1;
          if (bit_cnt == CNT_DATA_LAST) begin
            state_next = DONE;
            commit_wr  = rx_next[FRAME_LEN-1];
          end
        end
      end
      DONE: begin
        state_next = DONE;
      end
    endcase
    if (ncs_rise) state_next = IDLE;
  end

  // Receive shift register, saturating bit counter and the register bank.
  // Out-of-range addresses match no register, so they write nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      regs_flat <= '0;
      wr_strobe <= '0;
    end else begin
      wr_strobe <= '0;
      if (clear_frame) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (take_bit) begin
        rx_shift <= rx_next[FRAME_LEN-2:0];
        if (bit_cnt != CNT_FULL) bit_cnt <= bit_cnt + 1'b1;
      end
      if (commit_wr) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_addr == ADDR_W'(i)) begin
            regs_flat[i*DATA_W +: DATA_W] <= wr_data;
            wr_strobe[i]                  <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_shift, tx_load_val;
  logic              load_tx, shift_tx;

  // Load happens on every CMD->DATA step; writes load zero so CIPO stays
  // quiet during their data phase. The first falling edge after the load
  // must not shift, otherwise the MSB would be lost before the controller
  // samples it, hence the counter test on shift_tx.
  assign load_tx  = (state == CMD) && sclk_rise && (bit_cnt == CNT_CMD_LAST);
  assign shift_tx = (state == DATA) && sclk_fall && (bit_cnt > CNT_CMD_DONE);

  always_comb begin
    tx_load_val = '0;
    if (!rx_next[ADDR_W]) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rx_next[ADDR_W-1:0] == ADDR_W'(i)) tx_load_val = regs_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_shift <= '0;
    end else if (load_tx) begin
      tx_shift <= tx_load_val;
    end else if (shift_tx) begin
      tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
    end
  end

  assign CIPO    = (state == DATA) ? tx_shift[DATA_W-1] : 1'b0;
  assign cipo_oe = ~ncs_sync[1];
`else
  assign CIPO    = 1'b0;
  assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// tb_spi_regfile_peripheral
//
// Directed bench for spi_regfile_peripheral. Instance dut_a uses the default
// parameters, dut_b uses NUM_REGS=3, ADDR_W=2, DATA_W=16. Each instance has
// its own SPI pins; clk and rst_n are shared. Readback expectations follow
// SPI_READBACK_EN.

module tb_spi_regfile_peripheral;

`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic ncs_a, sclk_a, copi_a, cipo_a, oe_a;
  logic [39:0] regs_a;
  logic [4:0]  strobe_a;

  logic ncs_b, sclk_b, copi_b, cipo_b, oe_b;
  logic [47:0] regs_b;
  logic [2:0]  strobe_b;

  logic [4:0] acc_a;
  logic [2:0] acc_b;
  logic       acc_clear;

  int total  = 0;
  int passed = 0;

  logic        c_s, o_s, oe_all;
  logic [31:0] rx;

  always #5 clk = ~clk;

  spi_regfile_peripheral dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .nCS       (ncs_a),
    .SCLK      (sclk_a),
    .COPI      (copi_a),
    .CIPO      (cipo_a),
    .cipo_oe   (oe_a),
    .regs_flat (regs_a),
    .wr_strobe (strobe_a)
  );

  spi_regfile_peripheral #(.NUM_REGS(3), .ADDR_W(2), .DATA_W(16)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .nCS       (ncs_b),
    .SCLK      (sclk_b),
    .COPI      (copi_b),
    .CIPO      (cipo_b),
    .cipo_oe   (oe_b),
    .regs_flat (regs_b),
    .wr_strobe (strobe_b)
  );

  // Sticky record of every strobe bit seen since the last clear.
  always @(posedge clk) begin
    if (acc_clear) begin
      acc_a <= '0;
      acc_b <= '0;
    end else begin
      acc_a <= acc_a | strobe_a;
      acc_b <= acc_b | strobe_b;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearAcc();
    acc_clear = 1'b1;
    waitClk(2);
    acc_clear = 1'b0;
  endtask

  task automatic setNcs(input int sel, input logic v);
    if (sel == 0) ncs_a = v; else ncs_b = v;
  endtask

  task automatic setSclk(input int sel, input logic v);
    if (sel == 0) sclk_a = v; else sclk_b = v;
  endtask

  task automatic setCopi(input int sel, input logic v);
    if (sel == 0) copi_a = v; else copi_b = v;
  endtask

  task automatic spiBegin(input int sel);
    setSclk(sel, 1'b0);
    setNcs(sel, 1'b0);
  endtask

  // One bit: low phase with COPI set up, then SCLK rises and CIPO/cipo_oe
  // are sampled at the rise. SCLK is left high.
  task automatic spiBit(input int sel, input logic b, output logic cipo_s, output logic oe_s);
    waitClk(8);
    setSclk(sel, 1'b0);
    setCopi(sel, b);
    waitClk(8);
    setSclk(sel, 1'b1);
    cipo_s = (sel == 0) ? cipo_a : cipo_b;
    oe_s   = (sel == 0) ? oe_a : oe_b;
  endtask

  task automatic spiEnd(input int sel);
    waitClk(8);
    setSclk(sel, 1'b0);
    waitClk(8);
    setNcs(sel, 1'b1);
    setCopi(sel, 1'b0);
    waitClk(8);
  endtask

  // Sends the first nbits of a len-bit frame; rx collects CIPO samples,
  // oe_and is the AND of cipo_oe at every sample.
  task automatic applyStimulus(input int sel, input logic [31:0] frame, input int len, input int nbits,
                               output logic [31:0] rx_o, output logic oe_and);
    logic cs, os;
    rx_o   = '0;
    oe_and = 1'b1;
    spiBegin(sel);
    for (int k = 0; k < nbits; k++) begin
      spiBit(sel, frame[len-1-k], cs, os);
      rx_o   = {rx_o[30:0], cs};
      oe_and = oe_and & os;
    end
    spiEnd(sel);
  endtask

  initial begin
    logic [15:0] f16;
    rst_n     = 1'b0;
    acc_clear = 1'b1;
    ncs_a = 1'b1; sclk_a = 1'b0; copi_a = 1'b0;
    ncs_b = 1'b1; sclk_b = 1'b0; copi_b = 1'b0;
    waitClk(3);
    $display("[TB] reset state");
    checkOutput("reset_regs_a", 64'(regs_a), 64'h0);
    checkOutput("reset_strobe_a", 64'(strobe_a), 64'h0);
    checkOutput("reset_cipo_a", 64'(cipo_a), 64'h0);
    checkOutput("reset_oe_a", 64'(oe_a), 64'h0);
    checkOutput("reset_regs_b", 64'(regs_b), 64'h0);
    rst_n     = 1'b1;
    acc_clear = 1'b0;
    waitClk(2);

    $display("[TB] write 0xA5 to address 2 with latency checks");
    clearAcc();
    f16 = 16'h82A5;
    spiBegin(0);
    for (int k = 0; k < 16; k++) spiBit(0, f16[15-k], c_s, o_s);
    waitClk(3);
    checkOutput("wr_pre_reg2", 64'(regs_a[23:16]), 64'h00);
    checkOutput("wr_pre_strobe", 64'(strobe_a), 64'h0);
    waitClk(1);
    checkOutput("wr_reg2", 64'(regs_a[23:16]), 64'hA5);
    checkOutput("wr_strobe_pulse", 64'(strobe_a), 64'b00100);
    waitClk(1);
    checkOutput("wr_strobe_end", 64'(strobe_a), 64'h0);
    checkOutput("wr_regs_all", 64'(regs_a), 64'h0000A50000);
    spiEnd(0);
    checkOutput("wr_oe_idle", 64'(oe_a), 64'h0);
    checkOutput("wr_acc", 64'(acc_a), 64'b00100);

    $display("[TB] read address 2");
    clearAcc();
    applyStimulus(0, 32'h0200, 16, 16, rx, oe_all);
    checkOutput("rd2_data", 64'(rx[7:0]), RB ? 64'hA5 : 64'h00);
    checkOutput("rd2_oe_low", 64'(oe_all), RB ? 64'h1 : 64'h0);
    checkOutput("rd2_oe_idle", 64'(oe_a), 64'h0);
    checkOutput("rd2_acc", 64'(acc_a), 64'h0);
    checkOutput("rd2_regs", 64'(regs_a), 64'h0000A50000);

    $display("[TB] aborted write of 0xFF to address 0");
    clearAcc();
    applyStimulus(0, 32'h80FF, 16, 12, rx, oe_all);
    checkOutput("abort_regs", 64'(regs_a), 64'h0000A50000);
    checkOutput("abort_acc", 64'(acc_a), 64'h0);

    $display("[TB] write 0x5A to address 0");
    clearAcc();
    applyStimulus(0, 32'h805A, 16, 16, rx, oe_all);
    checkOutput("wr0_regs", 64'(regs_a), 64'h0000A5005A);
    checkOutput("wr0_acc", 64'(acc_a), 64'b00001);

    $display("[TB] out-of-range write and read of address 7");
    clearAcc();
    applyStimulus(0, 32'h873C, 16, 16, rx, oe_all);
    checkOutput("oor_wr_regs", 64'(regs_a), 64'h0000A5005A);
    checkOutput("oor_wr_acc", 64'(acc_a), 64'h0);
    applyStimulus(0, 32'h0700, 16, 16, rx, oe_all);
    checkOutput("oor_rd_data", 64'(rx[7:0]), 64'h00);

    $display("[TB] read address 0");
    clearAcc();
    applyStimulus(0, 32'h0000, 16, 16, rx, oe_all);
    checkOutput("rd0_data", 64'(rx[7:0]), RB ? 64'h5A : 64'h00);
    checkOutput("rd0_acc", 64'(acc_a), 64'h0);

    $display("[TB] parametrised instance: 0xBEEF to address 1");
    clearAcc();
    applyStimulus(1, 32'h5BEEF, 19, 19, rx, oe_all);
    checkOutput("p_regs", 64'(regs_b), 64'h0000BEEF0000);
    checkOutput("p_acc", 64'(acc_b), 64'b010);
    applyStimulus(1, 32'h10000, 19, 19, rx, oe_all);
    checkOutput("p_rd_data", 64'(rx[15:0]), RB ? 64'hBEEF : 64'h0000);
    checkOutput("p_rd_oe_low", 64'(oe_all), RB ? 64'h1 : 64'h0);
    checkOutput("p_other_dut_regs", 64'(regs_a), 64'h0000A5005A);

    $display("[TB] reset in the middle of a write frame");
    clearAcc();
    f16 = 16'h8177;
    spiBegin(0);
    for (int k = 0; k < 10; k++) spiBit(0, f16[15-k], c_s, o_s);
    rst_n = 1'b0;
    waitClk(1);
    rst_n = 1'b1;
    checkOutput("mid_rst_regs_a", 64'(regs_a), 64'h0);
    checkOutput("mid_rst_strobe", 64'(strobe_a), 64'h0);
    checkOutput("mid_rst_cipo", 64'(cipo_a), 64'h0);
    checkOutput("mid_rst_oe", 64'(oe_a), 64'h0);
    checkOutput("mid_rst_regs_b", 64'(regs_b), 64'h0);
    for (int k = 10; k < 16; k++) spiBit(0, f16[15-k], c_s, o_s);
    spiEnd(0);
    checkOutput("post_rst_tail_regs", 64'(regs_a), 64'h0);
    checkOutput("post_rst_tail_acc", 64'(acc_a), 64'h0);
    clearAcc();
    applyStimulus(0, 32'h8177, 16, 16, rx, oe_all);
    checkOutput("post_rst_wr_regs", 64'(regs_a), 64'h0000007700);
    checkOutput("post_rst_wr_acc", 64'(acc_a), 64'b00010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_regfile_peripheral.md
# spi_regfile_peripheral

Parametrised SPI mode-0 peripheral giving an external controller read and write access to a bank of `NUM_REGS` control registers of `DATA_W` bits each. It is the generalised successor to the fixed five-register write-only SPI front end. It adds configurable register count, address width and data width, optional register readback on CIPO, and a per-register write strobe. It sits between the chip pins and the output-enable/PWM control logic.

## Interface
- `NUM_REGS`, 5: number of implemented registers (1..2^`ADDR_W`)
- `ADDR_W`, 7: address field width in bits
- `DATA_W`, 8: register and data field width in bits
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `nCS`  in  1  chip select, active-low, asynchronous to `clk`
- `SCLK`  in  1  SPI clock, asynchronous to `clk`
- `COPI`  in  1  controller-out data, asynchronous to `clk`
- `CIPO`  out  1  peripheral-out data
- `cipo_oe`  out  1  output enable for the `CIPO` pad
- `regs_flat`  out  `NUM_REGS*DATA_W`  register contents; register i occupies bits [i*DATA_W +: DATA_W]
- `wr_strobe`  out  `NUM_REGS`  one-cycle pulse on bit i when register i is written

## Operation
- **Synchronisation:** `nCS`, `SCLK` and `COPI` each pass through a 2-flop synchroniser plus one history flop. Edges are detected from the synchronised values.
- **Frame format:** one frame per `nCS` low period, MSB first. Fields in order:
  - R/W bit: 1 = write, 0 = read
  - `ADDR_W` address bits
  - `DATA_W` data bits
  - Frame length F = 1+`ADDR_W`+`DATA_W` bits.
- **Bit timing:** COPI is sampled on each synchronised SCLK rising edge. CIPO changes only on synchronised SCLK falling edges, or at the read load point defined below.
- **States:**
  - IDLE: `nCS` high.
  - CMD: receiving R/W and address bits.
  - DATA: receiving or sending data bits.
  - DONE: F bits received.
- **Transitions:**
  - IDLE→CMD on the synchronised `nCS` falling edge; bit counter cleared.
  - CMD→DATA after bit 1+`ADDR_W`.
  - DATA→DONE after bit F.
  - Any state→IDLE on the synchronised `nCS` rising edge.
- **Write commit:** on entering DONE with R/W=1 and address < `NUM_REGS`:
  - register[address] ← data field
  - `wr_strobe`[address] pulses for exactly one cycle
- **Out-of-range write:** address ≥ `NUM_REGS`; no register changes, no strobe.
- **Read:** on the CMD→DATA transition with R/W=0:
  - The transmit shift register loads register[address], or 0 if the address is out of range.
  - `CIPO` presents the MSB immediately.
  - Each subsequent SCLK falling edge shifts out the next bit.
- **Abort:** `nCS` rising before DONE means no commit and no strobe; the frame is discarded.
- **Extra bits:** SCLK edges in DONE are ignored, and `CIPO`=0.
- **`cipo_oe`:** 1 whenever the synchronised `nCS` is low, else 0.
- **Bit counter:** width $clog2(F+1). It saturates at F and never wraps.

## Timing
- **Reset values:**
  - `regs_flat`=0, `wr_strobe`=0, `CIPO`=0, `cipo_oe`=0
  - state IDLE, counters and shift registers 0
  - synchronisers 0 for `SCLK`/`COPI`, 1 for `nCS`
- **Reset mid-frame:** frame abandoned, no commit, all of the above values restored on that edge.
- **Edge detect latency:** 3 `clk` cycles from a pin transition to its detected edge.
- **Write latency:** the register update and strobe occur on the 4th `clk` rising edge after the final SCLK rising edge reaches the pin.
- **Read load:** the first data bit is valid on `CIPO` 4 `clk` cycles after the last address-bit SCLK rising edge.
- **SCLK constraint:** SCLK high and low phases are each ≥ 4 `clk` periods. `nCS` setup and hold to SCLK are each ≥ 4 `clk` periods.
- **Simultaneous DONE and `nCS` rising edge detection:** the commit takes priority, then the block returns to IDLE.

## Configuration
- `SPI_READBACK_EN` defined:
  - read frames are supported as described above.
- `SPI_READBACK_EN` undefined:
  - transmit shift register omitted
  - `CIPO` and `cipo_oe` tied to 0
  - read frames are received and discarded with no side effects

## Test plan
- Write 0xA5 to address 2 (defaults) → register 2 = 0xA5 four cycles after the last SCLK rise; `wr_strobe`=5'b00100 for one cycle; other registers unchanged.
- Readback (with `SPI_READBACK_EN`): after the previous write, a read of address 2 → `CIPO` bits 1,0,1,0,0,1,0,1 sampled on the data SCLK rises; `cipo_oe`=1 only while `nCS` is low.
- Abort: write 0xFF to address 0, raising `nCS` after 12 bits → register 0 stays 0x00, no strobe; the next full frame works normally.
- Out of range: write 0x3C to address 7 → no register change, no strobe; a read of address 7 returns 0x00.
- Reset: pulse `rst_n` low for one cycle after 10 bits of a write → all outputs 0. The remainder of the frame has no effect; the next full frame commits correctly.
- Parametrised run: `NUM_REGS`=3, `ADDR_W`=2, `DATA_W`=16; write 0xBEEF to address 1 → `regs_flat`[31:16]=0xBEEF; readback matches.
